rca_share_ctrl: RTL and testbench



---
 rtl/rca_share_pkg.sv | 15 +
 rtl/rca_share_ctrl_rr_arb2.sv | 40 ++++
 rtl/rca_share_ctrl.sv | 133 +++++++++++++
 tb/tb_rca_share_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_share_pkg.sv
// Shared types and limits for the 4-bit adder sharing controller.
package rca_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned ID_W       = 1;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/rca_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer favours the requester not granted last.
module rr_arb2
    import rca_share_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid0,
    input  logic            valid1,
    input  logic            accept,
    output logic [ID_W-1:0] grant,
    output logic            any
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        any = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ptr_q;
        end else begin
            grant = valid1 ? 1'b1 : 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ~grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rca_share_ctrl.sv
// Sequencer sharing one external 4-bit ripple-carry adder between two requesters.
module rca_share_ctrl
    import rca_share_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_s,
    input  logic       add_co,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_sum,
    output logic       rsp_co,
    input  logic       rsp_ready,
    output logic       busy,
    output logic [7:0] done_cnt
);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("rca_share_ctrl: SETTLE_CYCLES out of range 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]      sum_q, sum_d;
    logic            co_q, co_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      done_q, done_d;

    logic [ID_W-1:0] grant;
    logic            any;
    logic            accept;

    assign accept = (state_q == IDLE) && any;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant  (grant),
        .any    (any)
    );

    // Readies are qualified by valid so "ready" means "taken this cycle".
    assign req0_ready = accept && (grant == 1'b0);
    assign req1_ready = accept && (grant == 1'b1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        id_d    = id_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    id_d    = grant;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    sum_d   = add_s;
                    co_d    = add_co;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            id_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            id_q    <= id_d;
            done_q  <= done_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_co    = co_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_q;

endmodule

// File: tb/tb_rca_share_ctrl.sv
// Directed bench for rca_share_ctrl with an ideal adder model on each instance.
module tb_rca_share_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       r0v, r1v, rdy0, rdy1, aco, rv, rid, rco, rrdy, busy;
    logic [3:0] r0a, r0b, r1a, r1b, aa, ab, as, rsum;
    logic [7:0] done;

    logic       u2_r0v, u2_r1v, u2_rdy0, u2_rdy1, u2_aco, u2_rv, u2_rid, u2_rco, u2_rrdy, u2_busy;
    logic [3:0] u2_r0a, u2_r0b, u2_r1a, u2_r1b, u2_aa, u2_ab, u2_as, u2_rsum;
    logic [7:0] u2_done;

    assign {aco, as}       = {1'b0, aa} + {1'b0, ab};
    assign {u2_aco, u2_as} = {1'b0, u2_aa} + {1'b0, u2_ab};

    rca_share_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(rdy0),
        .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(rdy1),
        .add_a(aa), .add_b(ab), .add_s(as), .add_co(aco),
        .rsp_valid(rv), .rsp_id(rid), .rsp_sum(rsum), .rsp_co(rco), .rsp_ready(rrdy),
        .busy(busy), .done_cnt(done)
    );

    rca_share_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(u2_r0v), .req0_a(u2_r0a), .req0_b(u2_r0b), .req0_ready(u2_rdy0),
        .req1_valid(u2_r1v), .req1_a(u2_r1a), .req1_b(u2_r1b), .req1_ready(u2_rdy1),
        .add_a(u2_aa), .add_b(u2_ab), .add_s(u2_as), .add_co(u2_aco),
        .rsp_valid(u2_rv), .rsp_id(u2_rid), .rsp_sum(u2_rsum), .rsp_co(u2_rco), .rsp_ready(u2_rrdy),
        .busy(u2_busy), .done_cnt(u2_done)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_done = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_add_a"}, 32'(aa), 32'(0));
        chk({tag, "_add_b"}, 32'(ab), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rv), 32'(0));
        chk({tag, "_rsp_id"}, 32'(rid), 32'(0));
        chk({tag, "_rsp_sum"}, 32'(rsum), 32'(0));
        chk({tag, "_rsp_co"}, 32'(rco), 32'(0));
        chk({tag, "_rdy0"}, 32'(rdy0), 32'(0));
        chk({tag, "_rdy1"}, 32'(rdy1), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // One full operation on the SETTLE_CYCLES=1 instance with rsp_ready high.
    task automatic op(input string tag, input logic v0, input logic v1,
                      input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] a1, input logic [3:0] b1,
                      input logic eid, input logic [3:0] ea, input logic [3:0] eb,
                      input logic [3:0] es, input logic eco);
        r0v = v0; r0a = a0; r0b = b0;
        r1v = v1; r1a = a1; r1b = b1;
        #1;
        chk({tag, "_rdy0"}, 32'(rdy0), 32'(!eid));
        chk({tag, "_rdy1"}, 32'(rdy1), 32'(eid));
        step();
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_rdy_settle"}, 32'({rdy0, rdy1}), 32'(0));
        chk({tag, "_rv_settle"}, 32'(rv), 32'(0));
        chk({tag, "_add_a"}, 32'(aa), 32'(ea));
        chk({tag, "_add_b"}, 32'(ab), 32'(eb));
        step();
        chk({tag, "_rv"}, 32'(rv), 32'(1));
        chk({tag, "_id"}, 32'(rid), 32'(eid));
        chk({tag, "_sum"}, 32'(rsum), 32'(es));
        chk({tag, "_co"}, 32'(rco), 32'(eco));
        step();
        exp_done++;
        chk({tag, "_rv_after"}, 32'(rv), 32'(0));
        chk({tag, "_busy_after"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        r0v = 0; r0a = 0; r0b = 0; r1v = 0; r1a = 0; r1b = 0; rrdy = 0;
        u2_r0v = 0; u2_r0a = 0; u2_r0b = 0; u2_r1v = 0; u2_r1a = 0; u2_r1b = 0; u2_rrdy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_u2_busy", 32'(u2_busy), 32'(0));
        rst_n = 1'b1;
        rrdy = 1'b1;
        step();

        // Single requesters
        op("t1", 1, 0, 4'h3, 4'h4, 4'h0, 4'h0, 0, 4'h3, 4'h4, 4'h7, 0);
        op("t2a", 0, 1, 4'h0, 4'h0, 4'hF, 4'h1, 1, 4'hF, 4'h1, 4'h0, 1);
        op("t2b", 0, 1, 4'h0, 4'h0, 4'h9, 4'h9, 1, 4'h9, 4'h9, 4'h2, 1);

        // Both valid: alternate starting from requester 0
        op("t3a", 1, 1, 4'h1, 4'h2, 4'h3, 4'h4, 0, 4'h1, 4'h2, 4'h3, 0);
        op("t3b", 1, 1, 4'h5, 4'h6, 4'h7, 4'h8, 1, 4'h7, 4'h8, 4'hF, 0);
        op("t3c", 1, 1, 4'h8, 4'h8, 4'h2, 4'h2, 0, 4'h8, 4'h8, 4'h0, 1);
        op("t3d", 1, 1, 4'hA, 4'h5, 4'hC, 4'hC, 1, 4'hC, 4'hC, 4'h8, 1);
        chk("t3_done", 32'(done), 32'(4 + 3));

        // Response stall
        rrdy = 1'b0;
        r0v = 1; r0a = 4'h5; r0b = 4'h6;
        r1v = 1; r1a = 4'hE; r1b = 4'hE;
        #1;
        chk("t4_rdy0", 32'(rdy0), 32'(1));
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t4_rv", 32'(rv), 32'(1));
            chk("t4_sum", 32'(rsum), 32'(4'hB));
            chk("t4_co", 32'(rco), 32'(0));
            chk("t4_id", 32'(rid), 32'(0));
            chk("t4_rdys", 32'({rdy0, rdy1}), 32'(0));
            chk("t4_busy", 32'(busy), 32'(1));
            step();
        end
        rrdy = 1'b1;
        step();
        exp_done++;
        chk("t4_rv_after", 32'(rv), 32'(0));
        chk("t4_done", 32'(done), 32'(exp_done));
        chk("t4_next_rdy1", 32'(rdy1), 32'(1));
        chk("t4_next_rdy0", 32'(rdy0), 32'(0));
        r0v = 0;
        r1v = 0;

        // Three-cycle settle on the second instance
        u2_r0v = 1; u2_r0a = 4'h2; u2_r0b = 4'h9; u2_rrdy = 1;
        #1;
        chk("t5_rdy0", 32'(u2_rdy0), 32'(1));
        step();
        u2_r0v = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_rv_early", 32'(u2_rv), 32'(0));
            chk("t5_add_a", 32'(u2_aa), 32'(4'h2));
            chk("t5_add_b", 32'(u2_ab), 32'(4'h9));
            chk("t5_busy", 32'(u2_busy), 32'(1));
            step();
        end
        chk("t5_rv", 32'(u2_rv), 32'(1));
        chk("t5_sum", 32'(u2_rsum), 32'(4'hB));
        chk("t5_co", 32'(u2_rco), 32'(0));
        chk("t5_add_a_hold", 32'(u2_aa), 32'(4'h2));
        step();
        chk("t5_rv_after", 32'(u2_rv), 32'(0));
        chk("t5_done", 32'(u2_done), 32'(1));
        chk("t5_add_b_hold", 32'(u2_ab), 32'(4'h9));

        // Reset in the middle of SETTLE, then wrap done_cnt
        r1v = 1; r1a = 4'h1; r1b = 4'h2;
        #1;
        chk("t6_rdy1", 32'(rdy1), 32'(1));
        step();
        r1v = 0;
        chk("t6_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        step();
        chk("t6_rst_rv", 32'(rv), 32'(0));
        rst_n = 1'b1;
        step();
        chk("t6_no_rsp", 32'(rv), 32'(0));
        chk("t6_busy_idle", 32'(busy), 32'(0));
        chk("t6_done0", 32'(done), 32'(0));
        r0v = 1; r0a = 4'h1; r0b = 4'h1;
        r1v = 1; r1a = 4'h2; r1b = 4'h2;
        #1;
        chk("t6_grant_rdy0", 32'(rdy0), 32'(1));
        chk("t6_grant_rdy1", 32'(rdy1), 32'(0));
        repeat (255 * 3) step();
        chk("t6_done255", 32'(done), 32'(255));
        repeat (3) step();
        chk("t6_wrap", 32'(done), 32'(0));
        r0v = 0;
        r1v = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
